// File: rtl/ex_hazard_controller_if.sv
// Hazard-controller handshake bundle: ID-stage operand/destination info and
// branch resolution in, stall/bubble/flush/forwarding selects and counters out.
interface ex_hazard_controller_if;
    logic        IDvalid;
    logic [4:0]  IDrs;
    logic [4:0]  IDrt;
    logic        IDusesRt;
    logic [4:0]  IDrd;
    logic        IDregWrite;
    logic        IDmem2Reg;
    logic        branchTaken;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    // Pipeline side: presents the ID instruction, consumes hazard controls.
    modport master (
        output IDvalid, IDrs, IDrt, IDusesRt, IDrd, IDregWrite, IDmem2Reg, branchTaken,
        input  stall, bubble, flush, fwdA, fwdB, stallCount, flushCount
    );

    // Controller side.
    modport slave (
        input  IDvalid, IDrs, IDrt, IDusesRt, IDrd, IDregWrite, IDmem2Reg, branchTaken,
        output stall, bubble, flush, fwdA, fwdB, stallCount, flushCount
    );
endinterface

// File: rtl/ex_hazard_controller.sv
// EX-stage hazard controller: tracks EX/MEM/WB shadow copies of the pipeline,
// detects load-use hazards, squashes on taken branches and selects ALU
// operand forwarding. A taken branch outranks a load-use stall.
module ex_hazard_controller (
    input  logic                         CLK,
    input  logic                         RST,
    ex_hazard_controller_if.slave        hz
);

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic [4:0] rd;
        logic       regWrite;
        logic       mem2Reg;
    } ex_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       regWrite;
        logic       mem2Reg;
    } mem_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       regWrite;
    } wb_t;

    ex_t         ex_q;
    mem_t        mem_q;
    wb_t         wb_q;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        load_use;
    logic        stall_w;
    logic        flush_w;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;

    // MEM holds the most recent producer so it is checked first. A load in MEM
    // has no data yet, so it falls through to the WB check.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input mem_t m, input wb_t w);
        if (m.v && m.regWrite && !m.mem2Reg && m.rd != 5'd0 && m.rd == src)
            return 2'b01;
        if (w.v && w.regWrite && w.rd != 5'd0 && w.rd == src)
            return 2'b10;
        return 2'b00;
    endfunction

    // Load-use detection; branch squash wins, and reset masks everything.
    always_comb begin
        load_use = hz.IDvalid && ex_q.v && ex_q.mem2Reg && ex_q.regWrite &&
                   (ex_q.rd != 5'd0) &&
                   ((ex_q.rd == hz.IDrs) || (hz.IDusesRt && (ex_q.rd == hz.IDrt)));
        flush_w  = hz.branchTaken && !RST;
        stall_w  = load_use && !hz.branchTaken && !RST;
    end

    // Operand forwarding selects for the instruction sitting in EX.
    always_comb begin
        // NOTE: defaults first so every path assigns both selects; no latch is inferred.
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_q.v && !RST) begin
            fwd_a = fwd_sel(ex_q.rs, mem_q, wb_q);
            if (ex_q.usesRt)
                fwd_b = fwd_sel(ex_q.rt, mem_q, wb_q);
        end
    end

    assign hz.stall      = stall_w;
    assign hz.bubble     = stall_w;
    assign hz.flush      = flush_w;
    assign hz.fwdA       = fwd_a;
    assign hz.fwdB       = fwd_b;
    assign hz.stallCount = stall_cnt;
    assign hz.flushCount = flush_cnt;

    // Shadow pipeline advance; a stall or flush puts a bubble into EX.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge value of its predecessor.
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= '{v: ex_q.v, rd: ex_q.rd, regWrite: ex_q.regWrite, mem2Reg: ex_q.mem2Reg};
            wb_q  <= '{v: mem_q.v, rd: mem_q.rd, regWrite: mem_q.regWrite};
            if (stall_w || flush_w) begin
                ex_q.v        <= 1'b0;
                ex_q.usesRt   <= 1'b0;
                ex_q.regWrite <= 1'b0;
                ex_q.mem2Reg  <= 1'b0;
            end else begin
                ex_q <= '{v: hz.IDvalid, rs: hz.IDrs, rt: hz.IDrt, usesRt: hz.IDusesRt,
                          rd: hz.IDrd, regWrite: hz.IDregWrite, mem2Reg: hz.IDmem2Reg};
            end
        end
    end

    // Saturating stall/flush event counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_w && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush_w && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule
